// File: rtl/mips_isa_pkg.sv
// Package: mips_isa_pkg
// Instruction field widths, bit positions, the packed instruction layout and
// the loader FSM state encoding shared by imm_packer and its sub-module.
package mips_isa_pkg;

    localparam int OPC_W   = 7;
    localparam int REG_W   = 5;
    localparam int IMM_W   = 15;

    // Field LSB positions inside the 32-bit instruction word
    localparam int IMM_LSB = 0;
    localparam int RS_LSB  = IMM_LSB + IMM_W;
    localparam int RD_LSB  = RS_LSB + REG_W;
    localparam int OPC_LSB = RD_LSB + REG_W;
    localparam int INSTR_W = OPC_LSB + OPC_W;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs;
        logic [IMM_W-1:0] imm;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Assemble an instruction word from its fields using the layout positions
    function automatic instr_t pack_instr(
        input logic [OPC_W-1:0] opc,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs,
        input logic [IMM_W-1:0] imm
    );
        logic [INSTR_W-1:0] w;
        w = '0;
        w[OPC_LSB +: OPC_W] = opc;
        w[RD_LSB  +: REG_W] = rd;
        w[RS_LSB  +: REG_W] = rs;
        w[IMM_LSB +: IMM_W] = imm;
        return instr_t'(w);
    endfunction

endpackage

// File: rtl/imm_narrow.sv
// Module: imm_narrow
// Combinational narrowing of a 32-bit signed immediate to IMM_W bits.
// fits is high when every bit from 31 down to IMM_W-1 equals the sign bit.
// Optional feature macro: IMM_PACKER_SATURATE_EN -- when defined, an
// out-of-range value is clamped to the most positive / most negative field
// value instead of being passed through truncated.
module imm_narrow #(
    parameter int IMM_W = 15
) (
    input  logic [31:0]      imm,
    output logic [IMM_W-1:0] imm15,
    output logic             fits
);

    logic [32-IMM_W:0] sign_bits_s;

    // Range check on the redundant sign bits, then truncate or clamp
    always_comb begin
        sign_bits_s = imm[31:IMM_W-1];
        fits        = (&sign_bits_s) | ~(|sign_bits_s);
        if (fits) begin
            imm15 = imm[IMM_W-1:0];
        end else begin
`ifdef IMM_PACKER_SATURATE_EN
            if (imm[31]) begin
                imm15 = {1'b1, {(IMM_W-1){1'b0}}};
            end else begin
                imm15 = {1'b0, {(IMM_W-1){1'b1}}};
            end
`else
            imm15 = imm[IMM_W-1:0];
`endif
        end
    end

endmodule

// File: rtl/imm_packer.sv
// Module: imm_packer
// Narrows signed immediates, packs them with opcode/rd/rs into instruction
// words and streams them into imem through a 2-entry buffer.
// Optional feature macro: IMM_PACKER_SATURATE_EN -- out-of-range immediates are
// clamped and still written; without it such words are dropped. Both variants
// count out-of-range immediates in err_cnt and set the sticky range_err.
module imm_packer #(
    parameter int IMM_W  = 15,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    input  logic              imem_busy,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              done,
    output logic              range_err,
    output logic [7:0]        err_cnt
);

    import mips_isa_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W+1)'(DEPTH - 1);

    state_t            state_r;
    state_t            state_s;
    instr_t            buf0_r;
    instr_t            buf1_r;
    instr_t            word_s;
    logic [1:0]        count_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W:0]   acc_cnt_r;
    logic [7:0]        err_cnt_r;
    logic              range_err_r;
    logic [IMM_W-1:0]  imm15_s;
    logic              fits_s;
    logic              ready_s;
    logic              start_s;
    logic              hs_s;
    logic              push_s;
    logic              pop_s;
    logic              oor_s;

    imm_narrow #(
        .IMM_W (IMM_W)
    ) u_imm_narrow (
        .imm   (in_imm),
        .imm15 (imm15_s),
        .fits  (fits_s)
    );

    // Handshake, buffer push/pop qualifiers and the packed word being accepted
    always_comb begin
        ready_s = 1'b0;
        start_s = 1'b0;
        if (rst_n && (state_r == ST_RUN) && (count_r < 2'd2) && (acc_cnt_r <= LAST_CNT)) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
        if (rst_n && start && ((state_r == ST_IDLE) || (state_r == ST_DONE))) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
        hs_s  = in_valid & ready_s;
        oor_s = hs_s & ~fits_s;
`ifdef IMM_PACKER_SATURATE_EN
        push_s = hs_s;
`else
        push_s = hs_s & fits_s;
`endif
        // No write may leave the block while reset is asserted
        pop_s  = rst_n & (count_r != 2'd0) & ~imem_busy;
        word_s = pack_instr(in_opcode, in_rd, in_rs, imm15_s);
    end

    // Next-state logic for the load sequence
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) state_s = ST_RUN;
                else         state_s = ST_IDLE;
            end
            ST_RUN: begin
                if ((hs_s && in_last) || (push_s && (acc_cnt_r == LAST_CNT))) state_s = ST_DRAIN;
                else                                                            state_s = ST_RUN;
            end
            ST_DRAIN: begin
                // Leave as the final buffered word is written so done follows it directly
                if ((count_r == 2'd0) || ((count_r == 2'd1) && pop_s)) state_s = ST_DONE;
                else                                                   state_s = ST_DRAIN;
            end
            ST_DONE: begin
                if (start_s) state_s = ST_RUN;
                else         state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_s;
    end

    // Two-entry FIFO: buf0 is the head, buf1 the second slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= 2'd0;
            buf0_r  <= '0;
            buf1_r  <= '0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) buf0_r <= word_s;
                    else                 buf1_r <= word_s;
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    buf0_r  <= buf1_r;
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        buf0_r <= word_s;
                    end else begin
                        buf0_r <= buf1_r;
                        buf1_r <= word_s;
                    end
                end
                default: count_r <= count_r;
            endcase
        end
    end

    // Write address (wraps after DEPTH words) and count of words accepted into the buffer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_r    <= '0;
            acc_cnt_r <= '0;
        end else if (start_s) begin
            addr_r    <= '0;
            acc_cnt_r <= '0;
        end else begin
            if (pop_s) begin
                if (addr_r == LAST_ADDR) addr_r <= '0;
                else                     addr_r <= addr_r + 1'b1;
            end
            if (push_s) begin
                acc_cnt_r <= acc_cnt_r + 1'b1;
            end
        end
    end

    // Saturating out-of-range counter and sticky error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_r   <= 8'd0;
            range_err_r <= 1'b0;
        end else if (start_s) begin
            err_cnt_r   <= 8'd0;
            range_err_r <= 1'b0;
        end else if (oor_s) begin
            if (err_cnt_r != 8'd255) err_cnt_r <= err_cnt_r + 8'd1;
            range_err_r <= 1'b1;
        end
    end

    assign in_ready   = ready_s;
    assign imem_we    = pop_s;
    assign imem_addr  = addr_r;
    assign imem_wdata = buf0_r;
    assign done       = (state_r == ST_DONE);
    assign range_err  = range_err_r;
    assign err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_imm_packer.sv
// Testbench for imm_packer (DEPTH=4). Stimulus pushes expected imem writes into
// a queue from a reference model; a monitor pops and compares on every write.
// Honours IMM_PACKER_SATURATE_EN for the expected out-of-range behaviour.
module tb_imm_packer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              start     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              in_last   = 1'b0;
    logic              imem_busy = 1'b0;
    logic [6:0]        in_opcode = 7'd0;
    logic [4:0]        in_rd     = 5'd0;
    logic [4:0]        in_rs     = 5'd0;
    logic [31:0]       in_imm    = 32'd0;
    logic              in_ready;
    logic              imem_we;
    logic              done;
    logic              range_err;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [7:0]        err_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [39:0] exp_q[$];
    int          m_addr = 0;
    int          m_acc  = 0;
    int          m_err  = 0;
    bit          m_rerr = 1'b0;
    bit          m_ended = 1'b0;
    bit          busy_rand = 1'b0;

    imm_packer #(
        .IMM_W  (15),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs      (in_rs),
        .in_imm     (in_imm),
        .in_last    (in_last),
        .imem_busy  (imem_busy),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .done       (done),
        .range_err  (range_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: the load as a list of accepted words
    task automatic model_accept(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs,
                                input logic [31:0] imm, input bit last);
        int          v;
        bit          fits;
        bit          wr;
        logic [14:0] fld;
        v    = $signed(imm);
        fits = (v >= -16384) && (v <= 16383);
        fld  = imm[14:0];
        wr   = 1'b1;
        if (!fits) begin
            if (m_err < 255) m_err++;
            m_rerr = 1'b1;
`ifdef IMM_PACKER_SATURATE_EN
            fld = (v < 0) ? 15'h4000 : 15'h3FFF;
`else
            wr = 1'b0;
`endif
        end
        if (wr) begin
            exp_q.push_back({8'(m_addr), op, rd, rs, fld});
            m_addr = (m_addr + 1) % DEPTH;
            m_acc++;
        end
        if (last || (m_acc == DEPTH)) m_ended = 1'b1;
    endtask

    // Offer one word for up to 'bound' cycles; called at a falling edge
    task automatic send_word(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs,
                             input logic [31:0] imm, input bit last, input int bound, output bit acc);
        in_opcode = op; in_rd = rd; in_rs = rs; in_imm = imm; in_last = last;
        in_valid  = 1'b1;
        acc       = 1'b0;
        for (int i = 0; (i < bound) && !acc; i++) begin
            #1;
            if (in_ready === 1'b1) begin
                acc = 1'b1;
                @(posedge clk);
                model_accept(op, rd, rs, imm, last);
            end else begin
                @(posedge clk);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_ok(input logic [31:0] imm, input bit last);
        bit a;
        send_word(7'($urandom), 5'($urandom), 5'($urandom), imm, last, 60, a);
        chk("accept", 40'(a), 40'd1);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        m_addr  = 0; m_acc = 0; m_err = 0; m_rerr = 1'b0; m_ended = 1'b0;
        #1;
        chk("start_done_clr", 40'(done), 40'd0);
        chk("start_addr_clr", 40'(imem_addr), 40'd0);
        chk("start_errcnt_clr", 40'(err_cnt), 40'd0);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; (i < 100) && !seen; i++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) seen = 1'b1;
        end
        chk("done", 40'(done), 40'd1);
        chk("queue_drained", 40'(exp_q.size()), 40'd0);
        chk("end_addr", 40'(imem_addr), 40'(m_addr));
        chk("err_cnt", 40'(err_cnt), 40'(m_err));
        chk("range_err", 40'(range_err), 40'(m_rerr));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, 40'(in_ready), 40'd0);
        chk({tag, "_imem_we"}, 40'(imem_we), 40'd0);
        chk({tag, "_imem_addr"}, 40'(imem_addr), 40'd0);
        chk({tag, "_imem_wdata"}, 40'(imem_wdata), 40'd0);
        chk({tag, "_done"}, 40'(done), 40'd0);
        chk({tag, "_range_err"}, 40'(range_err), 40'd0);
        chk({tag, "_err_cnt"}, 40'(err_cnt), 40'd0);
    endtask

    // Monitor: sample just before each rising edge and score every imem write
    always @(negedge clk) begin : monitor
        logic [39:0] e;
        #4;
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: actual addr=%h data=%h expected no write", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("imem_write", {imem_addr, imem_wdata}, e);
            end
        end
    end

    // Random imem back-pressure, changed well away from both clock edges
    always @(posedge clk) begin
        if (busy_rand) begin
            #2;
            imem_busy = ($urandom_range(0, 3) == 0);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit a;
        logic [31:0] imm;
        int n;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Three in-range immediates, last on the third
        do_start();
        send_ok(32'd5, 1'b0);
        send_ok(32'hFFFF_FFFF, 1'b0);
        send_ok(32'd16383, 1'b1);
        wait_done();

        // Positive overflow, counted on the following edge
        do_start();
        send_ok(32'h0000_4000, 1'b0);
        #1;
        chk("oor_err_cnt_next", 40'(err_cnt), 40'd1);
        chk("oor_range_err_next", 40'(range_err), 40'd1);
        @(negedge clk);
        send_ok(32'd7, 1'b1);
        wait_done();

        // Negative overflow carrying in_last ends the load by itself
        do_start();
        send_ok(32'd1, 1'b0);
        send_ok(32'hFFFF_BFFF, 1'b1);
        wait_done();

        // imem busy: two accepts fill the buffer, then input stalls
        imem_busy = 1'b1;
        do_start();
        send_ok(32'd100, 1'b0);
        send_ok(32'hFFFF_FF00, 1'b0);
        #1;
        chk("busy_ready_low", 40'(in_ready), 40'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("busy_ready_still_low", 40'(in_ready), 40'd0);
        @(negedge clk);
        imem_busy = 1'b0;
        send_ok(32'd3, 1'b0);
        send_ok(32'd4, 1'b1);
        wait_done();

        // DEPTH words then refusal, address wraps to 0
        do_start();
        for (int k = 0; k < 6; k++) begin
            if (k < DEPTH) begin
                send_word(7'(k), 5'(k), 5'(k + 1), 32'(k * 11), 1'b0, 60, a);
                chk("depth_accept", 40'(a), 40'd1);
                if (k == DEPTH - 1) begin
                    #1;
                    chk("depth_ready_low", 40'(in_ready), 40'd0);
                    @(negedge clk);
                end
            end else begin
                send_word(7'(k), 5'(k), 5'(k), 32'(k), 1'b0, 5, a);
                chk("depth_refuse", 40'(a), 40'd0);
            end
        end
        wait_done();

        // Reset with two words buffered: no write in the reset cycle, all outputs cleared
        imem_busy = 1'b1;
        do_start();
        send_ok(32'd9, 1'b0);
        send_ok(32'd10, 1'b0);
        rst_n     = 1'b0;
        imem_busy = 1'b0;
        exp_q.delete();
        #1;
        chk("reset_cycle_no_we", 40'(imem_we), 40'd0);
        @(negedge clk);
        #1;
        chk_all_zero("midload_reset");
        @(negedge clk);
        rst_n = 1'b1;
        do_start();
        send_ok(32'd42, 1'b1);
        wait_done();

        // Randomized loads under random back-pressure
        busy_rand = 1'b1;
        for (int l = 0; l < 40; l++) begin
            do_start();
            n = $urandom_range(1, 6);
            for (int k = 0; (k < n) && !m_ended; k++) begin
                case ($urandom_range(0, 5))
                    0:       imm = 32'($urandom_range(0, 200)) - 32'd100;
                    1:       imm = 32'd16383;
                    2:       imm = 32'hFFFF_C000;
                    3:       imm = 32'd16384;
                    4:       imm = 32'hFFFF_BFFF;
                    default: imm = $urandom;
                endcase
                send_ok(imm, (k == n - 1));
            end
            wait_done();
        end
        @(negedge clk);
        busy_rand = 1'b0;
        imem_busy = 1'b0;

        repeat (3) @(negedge clk);
        chk("final_queue_empty", 40'(exp_q.size()), 40'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
